vending_cfg_master: RTL
=======================

# vending_cfg_master

Configuration-bus initiator for the vending machine item table. It accepts item-level read/write commands from a local controller or boot sequencer, asserts `cfg_mode`, and issues single-beat psel/pwrite/paddr/pwdata transactions toward the vending machine's configuration port. It waits for `pready`, captures `prdata`, and returns one response per command. A bounded `pready` timeout prevents a dead slave from hanging the sequencer.

## Interface
- `MAX_ITEMS`, 1024, item table depth; item index width `IW = $clog2(MAX_ITEMS)`
- `TIMEOUT_CYCLES`, 64, consecutive sampled edges of psel high with pready low before abort (≥2)
- `pclk  in  1  config clock; all logic on rising edge`
- `prst  in  1  reset, synchronous, active-high`
- `session_en  in  1  request configuration session`
- `cfg_mode  out  1  configuration-mode request to the vending machine`
- `cmd_valid  in  1  command present`
- `cmd_ready  out  1  command accepted on edge with cmd_valid`
- `cmd_write  in  1  1 = write, 0 = read`
- `cmd_item  in  IW  item index`
- `cmd_wdata  in  32  entry data: [31:24] dispensed, [23:16] available, [15:0] price`
- `psel  out  1  transaction select`
- `pwrite  out  1  transaction direction`
- `paddr  out  15  byte address = (cmd_item + 1) << 2`
- `pwdata  out  32  write data`
- `pready  in  1  slave ready`
- `prdata  in  32  slave read data`
- `rsp_valid  out  1  one-cycle response pulse; no backpressure`
- `rsp_rdata  out  32  read data (0 for writes, except readback; see Configuration)`
- `rsp_err  out  1  timeout, out-of-range item, or readback mismatch`

## Operation
- Reset values: `cfg_mode`, `cmd_ready`, `psel`, `pwrite`, `rsp_valid`, `rsp_err` = 0; `paddr`, `pwdata`, `rsp_rdata` = 0; FSM = IDLE; timeout counter = 0.
- `cfg_mode` is a registered copy of `session_en`. A fall of `session_en` is deferred until the FSM is in IDLE.
- `cmd_ready` = (state == IDLE) && `cfg_mode` && !`pready` (registered).
- FSM states:
  - IDLE: on accept, latch the command.
    - If `cmd_item >= MAX_ITEMS`, go to RESP with `err` = 1 and issue no bus cycle.
    - Otherwise drive `psel` = 1, `pwrite`, `paddr`, `pwdata`, then go to ACCESS.
  - ACCESS: `psel` and all bus outputs stay stable.
    - On an edge sampling `pready` = 1: capture `prdata` (reads), then go to RECOVER.
    - Counter increments on each edge with `pready` = 0. At `TIMEOUT_CYCLES`: go to RECOVER with `err` = 1 and `rsp_rdata` = 0.
  - RECOVER: `psel` = 0; pulse `rsp_valid` for one cycle on entry; wait for `pready` sampled low (at least 1 cycle); then go to IDLE.
- `pwdata` = 0 during reads. The address counter arithmetic is 15-bit; with `IW` ≤ 12 it never overflows.
- `prst` mid-transaction: all outputs return to reset values on the next edge. The in-flight command is dropped with no response.

## Timing
- Edge E0 accepts the command. `psel` is high after E0. With a slave that raises `pready` one cycle after `psel`, `pready` is sampled at E2. `psel` falls and `rsp_valid` rises after E2.
- Back-to-back commands: minimum 4 cycles per command, because RECOVER waits for the slave's lingering `pready` to drop.
- Timeout path: `psel` is high for exactly `TIMEOUT_CYCLES` sampled edges, then `rsp_valid` with `rsp_err` = 1.
- Out-of-range item: `rsp_valid` 1 cycle after acceptance; `psel` never asserts.

## Configuration
- `VCFG_READBACK_EN` defined:
  - After a write completes RECOVER, the FSM issues a read to the same `paddr` (ACCESS → RECOVER) before responding.
  - `rsp_rdata` = read value.
  - `rsp_err` = (read value != written value) or timeout on either beat.
  - Write latency roughly doubles.
- `VCFG_READBACK_EN` undefined: a write responds after its single beat with `rsp_rdata` = 0.

## Test plan
- Reset mid-ACCESS with `prst` = 1 for 1 cycle → next cycle `psel` = 0, `rsp_valid` = 0, `cfg_mode` = 0, and no response for the dropped command.
- `session_en` = 1; write item 3, data 0x0005_0A0F → `paddr` = 0x0010, `pwdata` = 0x00050A0F, `pwrite` = 1. Then `rsp_valid` with `rsp_err` = 0; `rsp_rdata` = 0, or 0x00050A0F with readback.
- Read item 3 after that write (slave model returns stored data) → `paddr` = 0x0010, `pwrite` = 0, `rsp_rdata` = 0x00050A0F, `rsp_err` = 0.
- Slave never asserts `pready`, `TIMEOUT_CYCLES` = 64 → `psel` high for 64 edges, then `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0. The next command is accepted.
- `MAX_ITEMS` = 100, `cmd_item` = 120 → `rsp_err` = 1 one cycle after acceptance; no `psel`.
- `session_en` drops during an outstanding read → `cfg_mode` stays 1 until the response; `cmd_ready` stays 0 afterward.

Source files
------------

// File: rtl/vending_cfg_master.sv
// rtl/vending_cfg_master.sv - configuration-bus initiator for the vending machine item table
//
// Turns item-level read/write commands into single-beat psel/pwrite/paddr/pwdata
// transactions, waits for pready (with a bounded timeout), and returns one
// response per command.
//
// Optional feature: define VCFG_READBACK_EN to follow every write with a read of
// the same address; the response then carries the read value and flags a mismatch.
//
// Ports:
//   pclk, prst            clock, synchronous active-high reset
//   session_en / cfg_mode session request in, registered configuration-mode out
//   cmd_*                 command handshake (valid/ready), direction, item, write data
//   psel/pwrite/paddr/pwdata/pready/prdata  configuration bus initiator side
//   rsp_valid/rsp_rdata/rsp_err             one-cycle response pulse, no backpressure
module vending_cfg_master #(
  parameter int  MAX_ITEMS      = 1024,
  parameter int  TIMEOUT_CYCLES = 64,
  localparam int IW             = $clog2(MAX_ITEMS)
) (
  input  logic          pclk,
  input  logic          prst,
  input  logic          session_en,
  output logic          cfg_mode,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [IW-1:0] cmd_item,
  input  logic [31:0]   cmd_wdata,
  output logic          psel,
  output logic          pwrite,
  output logic [14:0]   paddr,
  output logic [31:0]   pwdata,
  input  logic          pready,
  input  logic [31:0]   prdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t        state_q, state_d;
  logic          cfg_mode_q, cfg_mode_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          psel_q, psel_d;
  logic          pwrite_q, pwrite_d;
  logic [14:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef VCFG_READBACK_EN
  logic          rb_pend_q, rb_pend_d;  // write beat done, readback beat still to issue
  logic          rb_chk_q, rb_chk_d;    // current beat is the readback of a write
  logic [31:0]   wr_data_q, wr_data_d;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
`ifdef VCFG_READBACK_EN
    rb_pend_d   = rb_pend_q;
    rb_chk_d    = rb_chk_q;
    wr_data_d   = wr_data_q;
`endif
    // A session may only end once the machine is back in IDLE.
    cfg_mode_d = (state_q == IDLE) ? session_en : (cfg_mode_q | session_en);

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (32'(cmd_item) >= 32'(MAX_ITEMS)) begin
            state_d     = RECOVER;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d  = ACCESS;
            psel_d   = 1'b1;
            pwrite_d = cmd_write;
            paddr_d  = (15'(cmd_item) + 15'd1) << 2;
            pwdata_d = cmd_write ? cmd_wdata : 32'd0;
            cnt_d    = '0;
          end
        end
      end
      ACCESS: begin
        if (pready) begin
          state_d = RECOVER;
          psel_d  = 1'b0;
          cnt_d   = '0;
`ifdef VCFG_READBACK_EN
          if (pwrite_q) begin
            rb_pend_d = 1'b1;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = prdata;
            rsp_err_d   = rb_chk_q && (prdata != wr_data_q);
            rb_chk_d    = 1'b0;
          end
`else
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? 32'd0 : prdata;
          rsp_err_d   = 1'b0;
`endif
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          // This edge is the TIMEOUT_CYCLES-th one sampled with pready low.
          state_d     = RECOVER;
          psel_d      = 1'b0;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'd0;
`ifdef VCFG_READBACK_EN
          rb_chk_d    = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RECOVER: begin
        // Let the slave's lingering pready drop before the next beat.
        if (!pready) begin
          state_d = IDLE;
`ifdef VCFG_READBACK_EN
          if (rb_pend_q) begin
            state_d   = ACCESS;
            psel_d    = 1'b1;
            pwrite_d  = 1'b0;
            pwdata_d  = 32'd0;
            wr_data_d = pwdata_q;
            rb_pend_d = 1'b0;
            rb_chk_d  = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered ready must already reflect the state being entered, so a
    // command is never accepted twice.
    cmd_ready_d = (state_d == IDLE) && cfg_mode_d && !pready;
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= IDLE;
      cfg_mode_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 15'd0;
      pwdata_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
`ifdef VCFG_READBACK_EN
      rb_pend_q   <= 1'b0;
      rb_chk_q    <= 1'b0;
      wr_data_q   <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      cfg_mode_q  <= cfg_mode_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
`ifdef VCFG_READBACK_EN
      rb_pend_q   <= rb_pend_d;
      rb_chk_q    <= rb_chk_d;
      wr_data_q   <= wr_data_d;
`endif
    end
  end

  assign cfg_mode  = cfg_mode_q;
  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
